axi_lite_arbiter: RTL and testbench
===================================

# axi_lite_arbiter

Two-master to one-slave AXI4-Lite arbiter that shares the single memory/device bus between the instruction fetch unit (m0) and the load/store unit (m1). Its slave-side port feeds the address-decoding crossbar, so both requesters reach the UART and main memory through one path. Exactly one transaction, read or write, is in flight at any time. It is held from grant until its response handshake completes.

## Interface
- Parameters: none; widths come from `axi_lite_if` (addr 32, data 32, wmask 4, resp 2).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0`  `axi_lite_if.slave`  bundle  requester 0 (IFU); normally read-only, but writes are legal.
- `m1`  `axi_lite_if.slave`  bundle  requester 1 (LSU); reads and writes.
- `s`  `axi_lite_if.master`  bundle  shared downstream port toward the crossbar.

## Operation
- Per-master request: `wreq_i = m_i.awvalid`, `rreq_i = m_i.arvalid`. Within one master, a write beats a read.
- FSM states:
  - IDLE: no owner; all forwarded valids/readies are 0.
  - RD_A: `s.arvalid/araddr` driven from the owner. Moves to RD_D on `s.arvalid && s.arready`.
  - RD_D: `s.rready = owner.rready`; owner sees `rvalid/rdata/rresp`. Moves to IDLE on `s.rvalid && owner.rready`.
  - WR_A: AW and W are forwarded independently from the owner. Flags `aw_done`/`w_done` are set on their respective handshakes. When both are done (including both in the same cycle), go to WR_B.
  - WR_B: `s.bready = owner.bready`; owner sees `bvalid/bresp`. Moves to IDLE on `s.bvalid && owner.bready`.
- IDLE transition:
  - If any request is pending, register `owner` and go to WR_A if the winner's request is a write, otherwise RD_A.
  - Clear `aw_done`/`w_done`.
- Non-owner master: every ready/valid output toward it is held at 0. Its `rdata`/`bresp` outputs carry don't-care values and are not checked.
- `aw_done` set: the owner's `awready` is forced low so the address is not accepted twice; the same applies to `wready` with `w_done`.
- The arbiter does no address decoding, response rewriting or buffering. Data/addr/mask pass through combinationally from owner to `s` and back.

## Timing
- Reset (asynchronous, `reset`=0):
  - State becomes IDLE, `owner`=m0, `last_grant`=m1, flags cleared.
  - All `s.*valid`, `s.*ready`, `m*.*valid` and `m*.*ready` outputs are 0.
  - A reset mid-transaction abandons the transaction; the downstream is reset by the same signal.
- Grant latency: a request first visible in IDLE at cycle N is forwarded on `s` at cycle N+1. Masters must hold valid and payload stable until ready (AXI rule).
- Turnaround: after the final R/B handshake in cycle K, the state is IDLE in K+1. The next grant is forwarded at K+2, so there is a one-cycle bubble between transactions.
- Simultaneous requests from both masters in IDLE are resolved by the arbitration policy (see Configuration).
- A request that arrives while the bus is busy waits; it is never dropped.
- If W arrives before AW (or vice versa) in WR_A, each channel completes independently.

## Configuration
- `AXI_ARB_RR_EN` defined: round-robin.
  - On a tie, the master not equal to `last_grant` wins.
  - `last_grant` updates on every grant.
  - The first tie after reset goes to m0.
- `AXI_ARB_RR_EN` undefined: fixed priority.
  - m1 (LSU) always wins ties.
  - `last_grant` is not implemented.

## Structure
- Package `axi_arb_pkg`:
  - `arb_state_t` enum {IDLE, RD_A, RD_D, WR_A, WR_B}.
  - `arb_owner_t` (1 bit, M0=0, M1=1).
- Sub-module `arb_pick`:
  - Combinational winner selection from `{wreq0, rreq0, wreq1, rreq1, last_grant}`.
  - Outputs the winner and `is_write`.
  - Contains the `AXI_ARB_RR_EN` conditional.
- Top level holds the FSM, owner/flag registers and channel muxing.

## Test plan
- Lone read: m0 `araddr`=0x8000_0000 in IDLE at cycle 0.
  - Expect `s.arvalid`=1 at cycle 1.
  - Slave returns `rdata`=0x0000_0413, which reaches `m0.rdata` with `m0.rvalid`=1.
  - State is IDLE one cycle after the handshake.
- Tie: m0 read at 0x8000_0000 and m1 write at 0xa000_03f8 (`wdata`=0x41, `wmask`=0x1) in the same cycle.
  - Fixed priority: m1 is granted first.
  - With RR: the first tie after reset grants m0; a repeated tie then grants m1.
- Split write: m1 `awvalid` at cycle 1, `wvalid` at cycle 4.
  - AW handshake occurs once.
  - `s.wvalid` appears at cycle 4.
  - `s.bready` is driven only in WR_B.
  - m0 sees no ready throughout.
- Back-pressure: hold `s.rvalid`=1 with `m1.rready`=0 for 3 cycles.
  - State stays RD_D; no new grant.
  - m0's pending `arvalid` is granted 2 cycles after `rready` rises.
- Mid-transaction reset: assert `reset`=0 in WR_A.
  - All valid/ready outputs go to 0 immediately (asynchronously).
  - After release, a fresh m0 read completes normally.
- Same-master write-before-read: m1 asserts `awvalid`+`wvalid` and `arvalid` together.
  - Write completes first (B handshake), then the read is granted at K+2.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI4-Lite arbiter.
// State encoding and owner identity used by the FSM and picker.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_A,
    WR_B
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle: 32-bit addr/data, 4-bit write mask, 2-bit resp.
// master drives requests; slave drives readies and responses.
interface axi_lite_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wmask,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wmask,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_arbiter_pick.sv
// Winner selection for the arbiter; round-robin when
// AXI_ARB_RR_EN is defined, otherwise fixed priority to m1.
module arb_pick
  import axi_arb_pkg::*;
(
  input  logic       wreq0,
  input  logic       rreq0,
  input  logic       wreq1,
  input  logic       rreq1,
`ifdef AXI_ARB_RR_EN
  input  arb_owner_t last_grant,
`endif
  output arb_owner_t winner,
  output logic       is_write
);

  logic req0;
  logic req1;

  assign req0 = wreq0 | rreq0;
  assign req1 = wreq1 | rreq1;

`ifdef AXI_ARB_RR_EN
  always_comb begin
    winner = req1 ? M1 : M0;
    if (req0 && req1)
      winner = (last_grant == M0) ? M1 : M0;
  end
`else
  assign winner = req1 ? M1 : M0;
`endif

  // A master's write outranks its own read.
  assign is_write = (winner == M1) ? wreq1 : wreq0;

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction in flight.
// Build option: AXI_ARB_RR_EN selects round-robin over fixed priority.
module axi_lite_arbiter
  import axi_arb_pkg::*;
(
  input logic       clk,
  input logic       reset,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);

  arb_state_t state;
  arb_owner_t owner;
  arb_owner_t win;
  logic       win_wr;
  logic       aw_done;
  logic       w_done;
  logic       any_req;
  logic       sel;
  logic       in_ra, in_rd, in_wa, in_wb;
  logic       o_awvalid, o_wvalid, o_bready;
  logic       o_arvalid, o_rready;
  logic       aw_hs, w_hs;

`ifdef AXI_ARB_RR_EN
  arb_owner_t last_grant;
`endif

  assign any_req = m0.awvalid | m0.arvalid
                 | m1.awvalid | m1.arvalid;

  arb_pick u_pick (
    .wreq0      (m0.awvalid),
    .rreq0      (m0.arvalid),
    .wreq1      (m1.awvalid),
    .rreq1      (m1.arvalid),
`ifdef AXI_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .winner     (win),
    .is_write   (win_wr)
  );

  assign sel   = (owner == M1);
  assign in_ra = (state == RD_A);
  assign in_rd = (state == RD_D);
  assign in_wa = (state == WR_A);
  assign in_wb = (state == WR_B);

  assign o_awvalid = sel ? m1.awvalid : m0.awvalid;
  assign o_wvalid  = sel ? m1.wvalid  : m0.wvalid;
  assign o_bready  = sel ? m1.bready  : m0.bready;
  assign o_arvalid = sel ? m1.arvalid : m0.arvalid;
  assign o_rready  = sel ? m1.rready  : m0.rready;

  assign s.awvalid = in_wa && o_awvalid && !aw_done;
  assign s.awaddr  = sel ? m1.awaddr : m0.awaddr;
  assign s.wvalid  = in_wa && o_wvalid && !w_done;
  assign s.wdata   = sel ? m1.wdata : m0.wdata;
  assign s.wmask   = sel ? m1.wmask : m0.wmask;
  assign s.bready  = in_wb && o_bready;
  assign s.arvalid = in_ra && o_arvalid;
  assign s.araddr  = sel ? m1.araddr : m0.araddr;
  assign s.rready  = in_rd && o_rready;

  assign aw_hs = s.awvalid && s.awready;
  assign w_hs  = s.wvalid && s.wready;

  assign m0.awready = in_wa && !sel && !aw_done && s.awready;
  assign m0.wready  = in_wa && !sel && !w_done && s.wready;
  assign m0.bvalid  = in_wb && !sel && s.bvalid;
  assign m0.bresp   = s.bresp;
  assign m0.arready = in_ra && !sel && s.arready;
  assign m0.rvalid  = in_rd && !sel && s.rvalid;
  assign m0.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;

  assign m1.awready = in_wa && sel && !aw_done && s.awready;
  assign m1.wready  = in_wa && sel && !w_done && s.wready;
  assign m1.bvalid  = in_wb && sel && s.bvalid;
  assign m1.bresp   = s.bresp;
  assign m1.arready = in_ra && sel && s.arready;
  assign m1.rvalid  = in_rd && sel && s.rvalid;
  assign m1.rdata   = s.rdata;
  assign m1.rresp   = s.rresp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= M0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (any_req) begin
            owner <= win;
            state <= win_wr ? WR_A : RD_A;
          end
        end
        RD_A: if (s.arvalid && s.arready) state <= RD_D;
        RD_D: if (s.rvalid && o_rready) state <= IDLE;
        WR_A: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // AW and W may finish in either order or together.
          if ((aw_done || aw_hs) && (w_done || w_hs))
            state <= WR_B;
        end
        WR_B: if (s.bvalid && o_bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= M1;
    else if (state == IDLE && any_req)
      last_grant <= win;
  end
`endif

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: the bench plays both
// requesters and the downstream slave with hand-computed checks.
module tb_axi_lite_arbiter;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   aw_cnt = 0;
  int   aw0;

  axi_lite_if m0_if ();
  axi_lite_if m1_if ();
  axi_lite_if s_if ();

  axi_lite_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (s_if.awvalid && s_if.awready) aw_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input arb_state_t e);
    chk(tag, 32'(dut.state), 32'(e));
  endtask

  task automatic clear_all();
    m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.wvalid = 0;
    m0_if.wdata = 0; m0_if.wmask = 0; m0_if.bready = 0;
    m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.rready = 0;
    m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.wvalid = 0;
    m1_if.wdata = 0; m1_if.wmask = 0; m1_if.bready = 0;
    m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.rready = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0;
    s_if.bresp = 0; s_if.arready = 0; s_if.rvalid = 0;
    s_if.rdata = 0; s_if.rresp = 0;
  endtask

  // Entered in a low phase with m0 owning RD_A.
  task automatic read_m0(input logic [31:0] d);
    s_if.arready = 1;
    #1 chk("rd0_arready", 32'(m0_if.arready), 1);
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rdata = d; m0_if.rready = 1;
    #1 chk("rd0_rvalid", 32'(m0_if.rvalid), 1);
    chk("rd0_rdata", m0_if.rdata, d);
    chk("rd0_m1_rvalid", 32'(m1_if.rvalid), 0);
    chk("rd0_rready", 32'(s_if.rready), 1);
    @(negedge clk);
    s_if.rvalid = 0; m0_if.rready = 0;
    #1 chk_state("rd0_idle", IDLE);
  endtask

  // Entered in a low phase with m1 owning WR_A, AW and W held.
  task automatic write_m1();
    s_if.awready = 1; s_if.wready = 1;
    #1 chk("wr1_awready", 32'(m1_if.awready), 1);
    chk("wr1_wready", 32'(m1_if.wready), 1);
    chk("wr1_m0_awready", 32'(m0_if.awready), 0);
    @(negedge clk);
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    s_if.awready = 0; s_if.wready = 0;
    s_if.bvalid = 1; m1_if.bready = 1;
    #1 chk_state("wr1_wrb", WR_B);
    chk("wr1_bready", 32'(s_if.bready), 1);
    chk("wr1_bvalid", 32'(m1_if.bvalid), 1);
    @(negedge clk);
    s_if.bvalid = 0; m1_if.bready = 0;
    #1 chk_state("wr1_idle", IDLE);
  endtask

  initial begin
    clear_all();
    repeat (2) @(negedge clk);
    #1 chk_state("rst_state", IDLE);
    chk("rst_s_valids", 32'({s_if.awvalid, s_if.wvalid,
        s_if.arvalid}), 0);
    chk("rst_s_readies", 32'({s_if.bready, s_if.rready}), 0);
    chk("rst_m_out", 32'({m0_if.arready, m0_if.awready,
        m1_if.arready, m1_if.rvalid, m1_if.bvalid}), 0);
    @(negedge clk);
    reset = 1;

    // Tie: m0 read vs m1 write, both raised in IDLE.
    @(negedge clk);
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0000;
    m1_if.awvalid = 1; m1_if.awaddr = 32'ha000_03f8;
    m1_if.wvalid = 1; m1_if.wdata = 32'h41; m1_if.wmask = 4'h1;
    #1 chk("tie_idle_no_fwd", 32'(s_if.arvalid | s_if.awvalid), 0);
    @(negedge clk);
`ifdef AXI_ARB_RR_EN
    #1 chk("tie_rr_ar", 32'(s_if.arvalid), 1);
    chk("tie_rr_aw", 32'(s_if.awvalid), 0);
    read_m0(32'h0000_0413);
    m0_if.arvalid = 1;
    @(negedge clk);
    #1 chk("tie2_rr_aw", 32'(s_if.awvalid), 1);
    chk("tie2_rr_ar", 32'(s_if.arvalid), 0);
    write_m1();
    @(negedge clk);
    #1 chk("tie2_rr_m0_ar", 32'(s_if.arvalid), 1);
    read_m0(32'h0000_0097);
`else
    #1 chk("tie_fp_aw", 32'(s_if.awvalid), 1);
    chk("tie_fp_ar", 32'(s_if.arvalid), 0);
    chk("tie_fp_awaddr", s_if.awaddr, 32'ha000_03f8);
    chk("tie_fp_wdata", s_if.wdata, 32'h41);
    chk("tie_fp_wmask", 32'(s_if.wmask), 1);
    chk("tie_fp_m0_arready", 32'(m0_if.arready), 0);
    write_m1();
    @(negedge clk);
    #1 chk("tie_fp_m0_ar", 32'(s_if.arvalid), 1);
    chk("tie_fp_araddr", s_if.araddr, 32'h8000_0000);
    read_m0(32'h0000_0413);
`endif

    // Lone read from m0.
    @(negedge clk);
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0000;
    #1 chk("lone_c0", 32'(s_if.arvalid), 0);
    @(negedge clk);
    #1 chk("lone_c1_ar", 32'(s_if.arvalid), 1);
    chk("lone_c1_addr", s_if.araddr, 32'h8000_0000);
    read_m0(32'h0000_0413);

    // Split write: AW first, W three cycles later, m0 read waits.
    aw0 = aw_cnt;
    @(negedge clk);
    m1_if.awvalid = 1; m1_if.awaddr = 32'h0000_1000;
    m1_if.bready = 1; s_if.awready = 1; s_if.wready = 1;
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0010;
    @(negedge clk);
    #1 chk("split_aw", 32'(s_if.awvalid), 1);
    chk("split_m1_awready", 32'(m1_if.awready), 1);
    chk("split_no_w", 32'(s_if.wvalid), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("split_aw_once", 32'(s_if.awvalid | m1_if.awready), 0);
      chk("split_bready_lo", 32'(s_if.bready), 0);
      chk("split_m0_quiet", 32'({m0_if.arready, m0_if.awready,
          m0_if.wready}), 0);
      chk_state("split_wra", WR_A);
    end
    @(negedge clk);
    m1_if.wvalid = 1; m1_if.wdata = 32'h55; m1_if.wmask = 4'hf;
    #1 chk("split_w", 32'(s_if.wvalid), 1);
    chk("split_wready", 32'(m1_if.wready), 1);
    chk("split_bready_lo2", 32'(s_if.bready), 0);
    @(negedge clk);
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    s_if.awready = 0; s_if.wready = 0;
    #1 chk_state("split_wrb", WR_B);
    chk("split_bready", 32'(s_if.bready), 1);
    chk("split_bvalid_lo", 32'(m1_if.bvalid), 0);
    @(negedge clk);
    s_if.bvalid = 1; s_if.bresp = 2'b10;
    #1 chk("split_bvalid", 32'(m1_if.bvalid), 1);
    chk("split_bresp", 32'(m1_if.bresp), 2);
    chk("split_m0_bvalid", 32'(m0_if.bvalid), 0);
    @(negedge clk);
    s_if.bvalid = 0; s_if.bresp = 0; m1_if.bready = 0;
    #1 chk_state("split_idle", IDLE);
    chk("split_aw_count", 32'(aw_cnt - aw0), 1);
    @(negedge clk);
    #1 chk("split_m0_granted", 32'(s_if.arvalid), 1);
    chk("split_m0_addr", s_if.araddr, 32'h8000_0010);
    read_m0(32'h1234_5678);

    // Back-pressure on m1 read while m0 waits.
    @(negedge clk);
    m1_if.arvalid = 1; m1_if.araddr = 32'h0000_2000;
    @(negedge clk);
    s_if.arready = 1;
    #1 chk("bp_ar", 32'(s_if.arvalid), 1);
    chk("bp_arready", 32'(m1_if.arready), 1);
    @(negedge clk);
    m1_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rdata = 32'hdead_beef;
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0004;
    for (int i = 0; i < 3; i++) begin
      #1 chk_state("bp_hold", RD_D);
      chk("bp_rready_lo", 32'(s_if.rready), 0);
      chk("bp_no_grant", 32'(s_if.arvalid | m0_if.arready), 0);
      chk("bp_m1_rvalid", 32'(m1_if.rvalid), 1);
      @(negedge clk);
    end
    m1_if.rready = 1;
    #1 chk("bp_rready", 32'(s_if.rready), 1);
    chk("bp_rdata", m1_if.rdata, 32'hdead_beef);
    @(negedge clk);
    s_if.rvalid = 0; m1_if.rready = 0;
    #1 chk_state("bp_idle", IDLE);
    chk("bp_k1_no_ar", 32'(s_if.arvalid), 0);
    @(negedge clk);
    #1 chk("bp_k2_ar", 32'(s_if.arvalid), 1);
    chk("bp_k2_addr", s_if.araddr, 32'h8000_0004);
    read_m0(32'h0000_0001);

    // Asynchronous reset while a write sits in WR_A.
    @(negedge clk);
    m1_if.awvalid = 1; m1_if.wvalid = 1;
    @(negedge clk);
    #1 chk("rst_mid_aw", 32'(s_if.awvalid), 1);
    #1 reset = 0;
    #1 chk("rst_mid_valids", 32'({s_if.awvalid, s_if.wvalid,
        s_if.arvalid}), 0);
    chk_state("rst_mid_state", IDLE);
    clear_all();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0008;
    @(negedge clk);
    #1 chk("rst_fresh_ar", 32'(s_if.arvalid), 1);
    chk("rst_fresh_addr", s_if.araddr, 32'h8000_0008);
    read_m0(32'hcafe_f00d);

    // Same-master write and read together: write goes first.
    @(negedge clk);
    m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.arvalid = 1;
    m1_if.araddr = 32'h0000_3000; m1_if.bready = 1;
    m1_if.rready = 1; s_if.awready = 1; s_if.wready = 1;
    @(negedge clk);
    #1 chk("wbr_aw", 32'(s_if.awvalid), 1);
    chk("wbr_no_ar", 32'(s_if.arvalid), 0);
    @(negedge clk);
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 1;
    #1 chk("wbr_bvalid", 32'(m1_if.bvalid), 1);
    @(negedge clk);
    s_if.bvalid = 0;
    #1 chk_state("wbr_k1_idle", IDLE);
    chk("wbr_k1_no_ar", 32'(s_if.arvalid), 0);
    @(negedge clk);
    s_if.arready = 1;
    #1 chk("wbr_k2_ar", 32'(s_if.arvalid), 1);
    chk("wbr_k2_addr", s_if.araddr, 32'h0000_3000);
    @(negedge clk);
    m1_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rdata = 32'h0bad_c0de;
    #1 chk("wbr_rvalid", 32'(m1_if.rvalid), 1);
    chk("wbr_rdata", m1_if.rdata, 32'h0bad_c0de);
    @(negedge clk);
    s_if.rvalid = 0;
    #1 chk_state("wbr_idle", IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
